// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between decode/control, the PC sequencer and instruction memory.
// The slave side is the sequencer; the master side is the decode/control unit and the fetch port.
interface pc_sequencer_if #(
    parameter int unsigned AW = 32
);
    logic [AW-1:0] sign_extend;
    logic          branch;
    logic          uncond_branch;
    logic          check;
    logic          br_reg;
    logic [AW-1:0] reg_target;
    logic          link;
    logic          ret;
    logic          exception;
    logic          stall;
    logic          fetch_ready;
    logic [AW-1:0] pc;
    logic          fetch_valid;
    logic          ras_overflow;
    logic          ras_underflow;

    modport master (
        output sign_extend, branch, uncond_branch, check, br_reg, reg_target,
               link, ret, exception, stall, fetch_ready,
        input  pc, fetch_valid, ras_overflow, ras_underflow
    );

    modport slave (
        input  sign_extend, branch, uncond_branch, check, br_reg, reg_target,
               link, ret, exception, stall, fetch_ready,
        output pc, fetch_valid, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer with branch/jump/return targets, fetch
// back-pressure, exception redirect and a circular return-address stack.
//
// state | meaning
// BOOT  | pc = RESET_VECTOR, no fetch request; always moves to RUN
// RUN   | pc presented as a valid fetch; advances when accepted and not stalled
// TRAP  | pc = EXC_VECTOR, no fetch request; moves to RUN unless another trap
module pc_sequencer #(
    parameter int unsigned   AW           = 32,
    parameter logic [AW-1:0] RESET_VECTOR = '0,
    parameter logic [AW-1:0] EXC_VECTOR   = AW'('h100),
    parameter int unsigned   RAS_DEPTH    = 4
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(RAS_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pc_q;
    logic          fetch_valid_q;
    logic          ras_overflow_q;
    logic          ras_underflow_q;

    logic [AW-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   ras_cnt;

    logic [AW-1:0] seq_pc;
    logic [AW-1:0] rel_pc;
    logic [AW-1:0] reg_tgt;
    logic [PW-1:0] top_ptr;
    logic [AW-1:0] ras_top;
    logic          ras_empty;
    logic          ras_full;
    logic          advance;
    logic [AW-1:0] nxt_pc;

    // Upper offset bits fall off the <<2; low target bits are forced to word alignment.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.sign_extend[AW-1:AW-2], bus.reg_target[1:0]};

    assign seq_pc    = pc_q + AW'(4);
    assign rel_pc    = pc_q + {bus.sign_extend[AW-3:0], 2'b00};
    assign reg_tgt   = {bus.reg_target[AW-1:2], 2'b00};
    assign top_ptr   = wr_ptr - PTR_ONE;
    assign ras_top   = ras_mem[top_ptr];
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_FULL);
    assign advance   = (state == ST_RUN) && fetch_valid_q && bus.fetch_ready && !bus.stall;

    always_comb begin
        nxt_pc = seq_pc;
        if (bus.ret) begin
            nxt_pc = ras_empty ? reg_tgt : ras_top;
        end else if (bus.br_reg) begin
            nxt_pc = reg_tgt;
        end else if (bus.uncond_branch || (bus.branch && bus.check)) begin
            nxt_pc = rel_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_BOOT;
            pc_q            <= RESET_VECTOR;
            fetch_valid_q   <= 1'b0;
            ras_overflow_q  <= 1'b0;
            ras_underflow_q <= 1'b0;
            wr_ptr          <= '0;
            ras_cnt         <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (bus.exception) begin
            // Trap wins over everything and leaves the return stack alone.
            state         <= ST_TRAP;
            pc_q          <= EXC_VECTOR;
            fetch_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state         <= ST_RUN;
                    pc_q          <= RESET_VECTOR;
                    fetch_valid_q <= 1'b1;
                end
                ST_TRAP: begin
                    state         <= ST_RUN;
                    pc_q          <= EXC_VECTOR;
                    fetch_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    fetch_valid_q <= 1'b1;
                    if (advance) begin
                        pc_q <= nxt_pc;
                        if (bus.ret && bus.link) begin
                            if (ras_empty) begin
                                ras_mem[wr_ptr] <= seq_pc;
                                wr_ptr          <= wr_ptr + PTR_ONE;
                                ras_cnt         <= CNT_ONE;
                                ras_underflow_q <= 1'b1;
                            end else begin
                                ras_mem[top_ptr] <= seq_pc;
                            end
                        end else if (bus.ret) begin
                            if (ras_empty) begin
                                ras_underflow_q <= 1'b1;
                            end else begin
                                wr_ptr  <= top_ptr;
                                ras_cnt <= ras_cnt - CNT_ONE;
                            end
                        end else if (bus.link) begin
                            // A full stack wraps onto its oldest entry.
                            ras_mem[wr_ptr] <= seq_pc;
                            wr_ptr          <= wr_ptr + PTR_ONE;
                            if (ras_full) begin
                                ras_overflow_q <= 1'b1;
                            end else begin
                                ras_cnt <= ras_cnt + CNT_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state         <= ST_BOOT;
                    pc_q          <= RESET_VECTOR;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc            = pc_q;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.ras_overflow  = ras_overflow_q;
    assign bus.ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random control traffic, all
// checked against a queue-based reference model of the fetch address stream.
module tb_pc_sequencer;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_V = 32'h0;
    localparam logic [31:0] EXC_V = 32'h100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.AW(AW)) bus ();

    pc_sequencer #(
        .AW(AW), .RESET_VECTOR(RST_V), .EXC_VECTOR(EXC_V), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_ovf;
    bit          m_unf;
    logic [31:0] m_ras[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        bus.sign_extend   = '0;
        bus.branch        = 1'b0;
        bus.uncond_branch = 1'b0;
        bus.check         = 1'b0;
        bus.br_reg        = 1'b0;
        bus.reg_target    = '0;
        bus.link          = 1'b0;
        bus.ret           = 1'b0;
        bus.exception     = 1'b0;
        bus.stall         = 1'b0;
        bus.fetch_ready   = 1'b1;
    endtask

    task automatic model_reset();
        m_pc    = RST_V;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_ras.delete();
    endtask

    // One clock of the reference: a trap request, a one-cycle idle after boot/trap,
    // or an accepted fetch that picks the next address and updates the call stack.
    task automatic model_step();
        logic [31:0] seq, rel, rt, tgt;
        if (bus.exception) begin
            m_pc    = EXC_V;
            m_valid = 1'b0;
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end else if (bus.fetch_ready && !bus.stall) begin
            seq = m_pc + 32'd4;
            rel = m_pc + (bus.sign_extend << 2);
            rt  = bus.reg_target & 32'hFFFF_FFFC;
            if (bus.ret) begin
                if (m_ras.size() == 0) begin
                    tgt   = rt;
                    m_unf = 1'b1;
                end else begin
                    tgt = m_ras[$];
                    void'(m_ras.pop_back());
                end
                if (bus.link) m_ras.push_back(seq);
            end else begin
                if (bus.link) begin
                    if (m_ras.size() == DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(seq);
                end
                if (bus.br_reg)                                    tgt = rt;
                else if (bus.uncond_branch || (bus.branch && bus.check)) tgt = rel;
                else                                               tgt = seq;
            end
            m_pc = tgt;
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_val({tag, ".pc"}, bus.pc, m_pc);
        check_val({tag, ".valid"}, 32'(bus.fetch_valid), 32'(m_valid));
        check_val({tag, ".ovf"}, 32'(bus.ras_overflow), 32'(m_ovf));
        check_val({tag, ".unf"}, 32'(bus.ras_underflow), 32'(m_unf));
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        clear_ctl();
        bus.br_reg     = 1'b1;
        bus.reg_target = addr;
        step("goto");
        clear_ctl();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] se;
        clear_ctl();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.pc", bus.pc, RST_V);
        check_val("rst.valid", 32'(bus.fetch_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("boot.valid", 32'(bus.fetch_valid), 32'h0);

        step("boot");
        check_val("boot_run.valid", 32'(bus.fetch_valid), 32'h1);
        check_val("boot_run.pc", bus.pc, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step("seq");
            check_val("seq.pc", bus.pc, 32'(4 * i));
        end

        goto_pc(32'h20);
        bus.branch = 1'b1; bus.sign_extend = 32'd3; bus.check = 1'b0;
        step("br_nt");
        check_val("br_nt.pc", bus.pc, 32'h24);
        goto_pc(32'h20);
        bus.branch = 1'b1; bus.sign_extend = 32'd3; bus.check = 1'b1;
        step("br_t");
        check_val("br_t.pc", bus.pc, 32'h2C);
        goto_pc(32'h20);
        bus.uncond_branch = 1'b1; bus.sign_extend = 32'hFFFF_FFFE;
        step("jmp");
        check_val("jmp.pc", bus.pc, 32'h18);

        goto_pc(32'h40);
        bus.branch = 1'b1; bus.check = 1'b1; bus.sign_extend = 32'd3; bus.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp");
            check_val("bp.hold", bus.pc, 32'h40);
            check_val("bp.valid", 32'(bus.fetch_valid), 32'h1);
        end
        bus.fetch_ready = 1'b1;
        step("bp_acc");
        check_val("bp_acc.pc", bus.pc, 32'h4C);

        goto_pc(32'h100);
        for (int k = 1; k <= 5; k++) begin
            clear_ctl();
            bus.link = 1'b1; bus.br_reg = 1'b1; bus.reg_target = 32'((k + 1) << 8);
            step("call");
        end
        check_val("call.ovf", 32'(bus.ras_overflow), 32'h1);
        for (int k = 0; k < 4; k++) begin
            clear_ctl();
            bus.ret = 1'b1;
            step("ret");
            check_val("ret.pc", bus.pc, 32'h504 - 32'(k * 32'h100));
        end
        clear_ctl();
        bus.ret = 1'b1; bus.reg_target = 32'h77;
        step("ret_empty");
        check_val("ret_empty.pc", bus.pc, 32'h74);
        check_val("ret_empty.unf", 32'(bus.ras_underflow), 32'h1);

        clear_ctl();
        bus.link = 1'b1; bus.br_reg = 1'b1; bus.reg_target = 32'h80;
        step("call80");
        clear_ctl();
        bus.stall = 1'b1; bus.exception = 1'b1;
        step("exc");
        check_val("exc.pc", bus.pc, EXC_V);
        check_val("exc.valid", 32'(bus.fetch_valid), 32'h0);
        clear_ctl();
        step("exc_run");
        check_val("exc_run.pc", bus.pc, EXC_V);
        check_val("exc_run.valid", 32'(bus.fetch_valid), 32'h1);
        bus.ret = 1'b1;
        step("exc_ret");
        check_val("exc_ret.pc", bus.pc, 32'h78);

        goto_pc(32'hFFFF_FFFC);
        step("wrap");
        check_val("wrap.pc", bus.pc, 32'h0);

        clear_ctl();
        bus.link = 1'b1; bus.br_reg = 1'b1; bus.reg_target = 32'h300;
        step("pre_rst");
        clear_ctl();
        bus.ret = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("arst.pc", bus.pc, RST_V);
        check_val("arst.valid", 32'(bus.fetch_valid), 32'h0);
        check_val("arst.ovf", 32'(bus.ras_overflow), 32'h0);
        check_val("arst.unf", 32'(bus.ras_underflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_ctl();
        step("reboot");
        bus.ret = 1'b1; bus.reg_target = 32'h77;
        step("arst_ret");
        check_val("arst_ret.pc", bus.pc, 32'h74);
        check_val("arst_ret.unf", 32'(bus.ras_underflow), 32'h1);

        for (int n = 0; n < 600; n++) begin
            se = $urandom();
            if ($urandom_range(0, 3) != 0) se = {{24{se[7]}}, se[7:0]};
            bus.sign_extend   = se;
            bus.branch        = ($urandom_range(0, 9) < 3);
            bus.check         = ($urandom_range(0, 1) == 1);
            bus.uncond_branch = ($urandom_range(0, 9) == 0);
            bus.br_reg        = ($urandom_range(0, 9) == 0);
            bus.reg_target    = $urandom();
            bus.link          = ($urandom_range(0, 4) == 0);
            bus.ret           = ($urandom_range(0, 4) == 0);
            bus.exception     = ($urandom_range(0, 39) == 0);
            bus.stall         = ($urandom_range(0, 6) == 0);
            bus.fetch_ready   = ($urandom_range(0, 4) != 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-issue processor. It replaces the fixed 32-bit combinational PC update with a registered PC that:
- computes sequential, conditional/unconditional branch, register-indirect and return targets;
- holds on stall or instruction-memory back-pressure;
- redirects to an exception vector.

It sits between the decode/control unit and instruction memory, and it owns an internal return-address stack (RAS) used by link/return instructions.

## Interface
Parameters:
- AW, 32: address width in bits (≥ 8).
- RESET_VECTOR, 0: PC value loaded by reset.
- EXC_VECTOR, 'h100: PC value loaded on exception.
- RAS_DEPTH, 4: return-address stack entries (power of two, ≥ 2).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sign_extend  in  AW  sign-extended word offset of the current instruction.
- branch  in  1  conditional branch instruction.
- uncond_branch  in  1  unconditional PC-relative branch.
- check  in  1  branch condition (ALU zero); qualifies branch only.
- br_reg  in  1  register-indirect jump to reg_target.
- reg_target  in  AW  register jump address.
- link  in  1  push return address (pc+4) onto RAS.
- ret  in  1  return: pop RAS and jump to the popped address.
- exception  in  1  trap request.
- stall  in  1  pipeline hold.
- fetch_ready  in  1  instruction memory accepts the address.
- pc  out  AW  current fetch address.
- fetch_valid  out  1  pc is a valid fetch request.
- ras_overflow  out  1  sticky: a push occurred while the RAS was full.
- ras_underflow  out  1  sticky: a pop occurred while the RAS was empty.

## Operation
- All arithmetic is modulo 2^AW.
  - seq = pc + 4.
  - rel = pc + (sign_extend << 2); the top 2 bits of sign_extend are discarded.
  - Bits [1:0] of reg_target and of RAS entries are forced to 0.
- An advance occurs when state = RUN, fetch_valid, fetch_ready and !stall are all true. Control inputs are sampled only on an advance cycle and are ignored otherwise.
- Next-PC priority on advance, highest first:
  1. ret → RAS top; if the RAS is empty, reg_target is used instead and ras_underflow is set.
  2. br_reg → reg_target.
  3. uncond_branch, or (branch & check) → rel.
  4. Otherwise → seq.
- RAS behaviour on advance:
  - link alone: push seq. When full, the push overwrites the oldest entry (circular), the count stays at RAS_DEPTH, and ras_overflow is set.
  - ret alone: pop. When empty, nothing changes except ras_underflow.
  - link & ret together: the target is the old top; that top entry is replaced by seq and the count is unchanged. When empty, the target is reg_target, seq is pushed (count becomes 1), and ras_underflow is set.
  - link with a non-ret redirect: the push happens and the redirect target applies.
- FSM states:
  - BOOT: pc = RESET_VECTOR, fetch_valid = 0. Next state is always RUN.
  - RUN: fetch_valid = 1.
  - TRAP: pc = EXC_VECTOR, fetch_valid = 0. Next state is always RUN.
- Exception handling:
  - exception in any state, with or without stall or fetch_ready, loads pc ← EXC_VECTOR and sends the FSM to TRAP.
  - The exception has priority over all other inputs.
  - The RAS is untouched.
  - An exception raised while in TRAP keeps the FSM in TRAP for another cycle.
- Reset (asynchronous, any time including mid-redirect):
  - pc = RESET_VECTOR, state = BOOT, fetch_valid = 0.
  - RAS count = 0, entries = 0.
  - ras_overflow = 0, ras_underflow = 0.
- The sticky flags clear only on reset.

## Timing
- pc is registered. A redirect decided in cycle N appears on pc in cycle N+1. There are no bubbles in RUN.
- After rst_n rises:
  - first edge: BOOT, fetch_valid 0;
  - second edge: RUN, with pc = RESET_VECTOR presented valid.
- An exception at edge N gives pc = EXC_VECTOR with fetch_valid 0 for one cycle, then RUN with pc = EXC_VECTOR valid from edge N+1.
- Fetch handshake: while fetch_valid && !fetch_ready, pc stays stable and fetch_valid stays 1. Stall behaves identically.
- Flags update on the same edge as the offending push or pop.
- There is no combinational path from any input to pc or fetch_valid.

## Test plan
- Reset and sequential fetch: release rst_n, hold fetch_ready = 1 with no controls → fetch_valid rises one cycle after BOOT, and pc runs 0, 4, 8, 12.
- Branches at pc = 0x20 with sign_extend = 3:
  - branch = 1, check = 0 → next pc 0x24;
  - branch = 1, check = 1 → 0x2C;
  - uncond_branch = 1, sign_extend = -2 (all ones, ...FE) → 0x18.
- Back-pressure: at pc = 0x40, fetch_ready = 0 for 3 cycles with a branch asserted → pc holds 0x40 and fetch_valid = 1; the branch takes effect only on the accepting cycle.
- RAS with RAS_DEPTH = 4:
  - 5 link calls at pc 0x100, 0x200, 0x300, 0x400, 0x500 → ras_overflow = 1;
  - 4 returns yield 0x504, 0x404, 0x304, 0x204;
  - a 5th return with reg_target = 0x77 → pc 0x74 and ras_underflow = 1.
- Exception: assert exception while stall = 1 at pc = 0x80 → next cycle pc = 0x100 with fetch_valid 0, then RUN at 0x100; RAS count is unchanged.
- Wrap and reset: at pc = 0xFFFFFFFC with no branch → pc 0x0. Assert rst_n low mid-cycle during a ret → pc = 0 immediately, flags 0, RAS empty.
